wave_sequencer: RTL
===================

Name: wave_sequencer

Overview:
Playlist controller for the 5-bit signal generator (square/sawtooth/triangle). Holds a small program table of segments. Each segment is a wave type plus a repeat count in whole periods. On start it drives the generator's wave select and a phase-clear strobe, one segment after another, with optional looping. Sits between the register/config interface and the generator instance.

Parameters:
DEPTH, 8, number of program table entries (power of 2, 2..16)
REP_W, 8, width of per-entry repeat count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  program table write strobe
cfg_addr  in  $clog2(DEPTH)  table write address
cfg_wdata  in  2+REP_W  {wave_type[1:0], reps[REP_W-1:0]}
num_entries  in  $clog2(DEPTH)+1  active entries 0..DEPTH, sampled at start
loop_en  in  1  restart at entry 0 after last entry, sampled at start
start  in  1  one-cycle start request
abort  in  1  one-cycle abort request
wave_choise  out  2  to generator select input
gen_clr  out  1  to generator, active-high synchronous phase clear
busy  out  1  high in CLEAR/RUN
done  out  1  one-cycle pulse at natural end of program
cur_entry  out  $clog2(DEPTH)  index of the segment being played

Behaviour:
- Reset values: wave_choise=2'b11 (generator outputs 0), gen_clr=0, busy=0, done=0, cur_entry=0, state=IDLE. Program table is not reset.
- Wave types: 00 square (period 20 clk), 01 sawtooth (period 21), 10 triangle (period 40), 11 silence (period 16, generator held at 0).
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start with num_entries!=0: latch num_entries and loop_en, idx=0, go to CLEAR.
  - start with num_entries==0: ignored, no done.
- CLEAR (exactly 1 cycle):
  - gen_clr=1; wave_choise=type of entry idx.
  - Load period counter = PERIOD[type]-1 and rep_left = reps.
  - If reps==0: advance immediately (segment skipped, costs 1 cycle). Otherwise go to RUN.
- RUN:
  - wave_choise=type; period counter decrements each cycle.
  - Counter==0 and rep_left>1: rep_left-1, reload counter. No gen_clr and no bubble; periods are back-to-back.
  - Counter==0 and rep_left==1: advance.
- Advance:
  - If idx<latched_num-1: idx+1, go to CLEAR.
  - Else if loop_en latched: idx=0, go to CLEAR.
  - Else go to DONE.
- DONE: done=1 for 1 cycle, wave_choise=11, then IDLE.
- Segment duration = 1 + reps*PERIOD cycles (the CLEAR cycle included).
- abort: from any state, go to IDLE on the next edge. wave_choise=11, busy=0, no done. abort wins over a simultaneous start.
- start while busy: ignored.
- cfg_we while busy: ignored (table is frozen during play). Writes in IDLE/DONE take effect on the next start.
- An entry written in the same cycle as start uses the new value.
- cur_entry tracks idx and holds its last value in IDLE.
- Counter width is 6 bits, enough for max period 40. rep_left is REP_W bits. No wrap: reps=2^REP_W-1 plays fully.
- Reset mid-operation: asynchronous return to reset values. gen_clr is not asserted by reset.

Decomposition:
- Package wave_seq_pkg:
  - typedef wave_t (enum SQUARE/SAW/TRI/SILENT).
  - typedef seg_t (wave_t + reps).
  - constants PERIOD_SQ=20, PERIOD_SAW=21, PERIOD_TRI=40, PERIOD_SIL=16.
  - function period_of(wave_t).
- Sub-module wave_seq_table: DEPTH x seg_t register file with synchronous write and combinational read, write gated by ~busy.

Test Plan:
- Program {SQ,reps=2} and num_entries=1, loop_en=0, pulse start. Expect gen_clr at cycle 1, wave_choise=00 for 40 cycles, done pulse at cycle 42, then IDLE with wave_choise=11.
- Program {SAW,1},{TRI,1},{SIL,3} and start. Expect segment boundaries at cycles 1, 23, 64; done at cycle 113; cur_entry 0→1→2; exactly one gen_clr per segment.
- Program {SQ,0},{TRI,1}. Expect a 1-cycle skip of entry 0, then TRI for 40 cycles; done at cycle 43.
- loop_en=1 with {SQ,1},{SAW,1}, start, run 200 cycles. Expect continuous alternation with period 43 and no done. Then abort: wave_choise=11 and busy=0 on the next edge, no done.
- Attempt a cfg_we on entry 0 and a second start while busy. Expect table contents and sequence unchanged; the write is visible after returning to IDLE.
- Assert rst mid-RUN. Expect outputs return to reset values immediately; num_entries=0 with start gives no busy and no done.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wave sequencer.
//   wave_t    : generator wave select encoding (11 = silence, generator held at 0)
//   seg_t     : one program-table segment at the default repeat width
//   state_t   : sequencer FSM states
//   period_of : generator period in clocks for each wave type
package wave_seq_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        SAW    = 2'b01,
        TRI    = 2'b10,
        SILENT = 2'b11
    } wave_t;

    localparam int SEG_REP_W = 8;

    typedef struct packed {
        wave_t                wave;
        logic [SEG_REP_W-1:0] reps;
    } seg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    localparam int PERIOD_SQ  = 20;
    localparam int PERIOD_SAW = 21;
    localparam int PERIOD_TRI = 40;
    localparam int PERIOD_SIL = 16;

    // Wide enough for the longest period (40).
    localparam int CNT_W = 6;

    function automatic logic [CNT_W-1:0] period_of(wave_t w);
        case (w)
            SQUARE:  return CNT_W'(PERIOD_SQ);
            SAW:     return CNT_W'(PERIOD_SAW);
            TRI:     return CNT_W'(PERIOD_TRI);
            default: return CNT_W'(PERIOD_SIL);
        endcase
    endfunction

endpackage

// File: rtl/wave_seq_if.sv
// Configuration / control / generator-side bundle of the wave sequencer.
//   master : register block side (drives table writes, start/abort)
//   slave  : sequencer side (drives generator select, clear, status)
interface wave_seq_if #(
    parameter int DEPTH = 8,
    parameter int REP_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [REP_W+1:0] cfg_wdata;     // {wave_type[1:0], reps}
    logic [AW:0]      num_entries;
    logic             loop_en;
    logic             start;
    logic             abort;
    logic [1:0]       wave_choise;
    logic             gen_clr;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cur_entry;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, num_entries, loop_en, start, abort,
        input  wave_choise, gen_clr, busy, done, cur_entry
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, num_entries, loop_en, start, abort,
        output wave_choise, gen_clr, busy, done, cur_entry
    );
endinterface

// File: rtl/wave_seq_table.sv
// Program table: DEPTH segments of {wave_type, reps}.
//   clk            : clock
//   we/waddr/wdata : synchronous write, ignored while busy (table frozen during play)
//   raddr          : combinational read address
//   rd_wave/rd_reps: segment at raddr
// The table has no reset; contents persist across resets.
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int REP_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             busy,
    input  logic [AW-1:0]    waddr,
    input  logic [REP_W+1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output wave_t            rd_wave,
    output logic [REP_W-1:0] rd_reps
);
    logic [REP_W+1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we && !busy) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_wave = wave_t'(mem_q[raddr][REP_W+1:REP_W]);
    assign rd_reps = mem_q[raddr][REP_W-1:0];
endmodule

// File: rtl/wave_sequencer.sv
// Playlist controller for the square/sawtooth/triangle generator.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : wave_seq_if slave (table writes, start/abort, generator select,
//              phase clear, busy/done status, current entry)
// Each segment costs one CLEAR cycle (gen_clr high) followed by reps whole
// generator periods in RUN; periods within a segment are back-to-back.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int REP_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    wave_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      num_q, num_d;
    logic             loop_q, loop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    wave_t            wave_q, wave_d;

    wave_t            tbl_wave;
    logic [REP_W-1:0] tbl_reps;

    state_t           adv_state;
    logic [AW-1:0]    adv_idx;

    wave_seq_table #(.DEPTH(DEPTH), .REP_W(REP_W)) u_table (
        .clk     (clk),
        .we      (bus.cfg_we),
        .busy    (bus.busy),
        .waddr   (bus.cfg_addr),
        .wdata   (bus.cfg_wdata),
        .raddr   (idx_q),
        .rd_wave (tbl_wave),
        .rd_reps (tbl_reps)
    );

    // Where to go when the current segment finishes (or is skipped).
    always_comb begin
        adv_state = S_DONE;
        adv_idx   = idx_q;
        if (({1'b0, idx_q} + (AW+1)'(1)) < num_q) begin
            adv_state = S_CLEAR;
            adv_idx   = idx_q + AW'(1);
        end else if (loop_q) begin
            adv_state = S_CLEAR;
            adv_idx   = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        wave_d  = wave_q;
        // Abort freezes everything except the state, so cur_entry keeps
        // showing the segment that was interrupted.
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && (bus.num_entries != '0)) begin
                        num_d   = bus.num_entries;
                        loop_d  = bus.loop_en;
                        idx_d   = '0;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    wave_d = tbl_wave;
                    cnt_d  = period_of(tbl_wave) - CNT_W'(1);
                    rep_d  = tbl_reps;
                    if (tbl_reps == '0) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (rep_q > REP_W'(1)) begin
                        rep_d = rep_q - REP_W'(1);
                        cnt_d = period_of(wave_q) - CNT_W'(1);
                    end else begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            loop_q  <= 1'b0;
            cnt_q   <= '0;
            rep_q   <= '0;
            wave_q  <= SILENT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            wave_q  <= wave_d;
        end
    end

    // In CLEAR the select comes straight from the table so the generator
    // sees the new wave in the same cycle as its phase clear.
    always_comb begin
        bus.wave_choise = SILENT;
        if (state_q == S_CLEAR) begin
            bus.wave_choise = tbl_wave;
        end else if (state_q == S_RUN) begin
            bus.wave_choise = wave_q;
        end
    end

    assign bus.gen_clr   = (state_q == S_CLEAR);
    assign bus.busy      = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.cur_entry = idx_q;
endmodule
